// File: rtl/ahb_to_psxddr_if.sv
// AHB-Lite subordinate bus bundle for the PSX DDR bridge.
// HREADY is the bus-level ready fed back from the interconnect.
interface ahb_to_psxddr_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [7:0]  HWSTRB;
    logic [63:0] HWDATA;
    logic        HREADY;
    logic [63:0] HRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
        output HWSTRB, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
        input  HWSTRB, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_to_psxddr.sv
// AHB-Lite 64-bit subordinate to PSX DDRAM single-beat request bridge.
// One outstanding DDRAM request at a time; bursts are split into singles.
module ahb_to_psxddr (
    input  logic                 HCLK,
    input  logic                 RESETN,
    ahb_to_psxddr_if.slave       ahb,
    input  logic                 DDRAM_BUSY,
    output logic [7:0]           DDRAM_BURSTCNT,
    output logic [28:0]          DDRAM_ADDR,
    output logic                 DDRAM_RD,
    output logic                 DDRAM_WE,
    output logic [63:0]          DDRAM_DIN,
    output logic [7:0]           DDRAM_BE,
    input  logic [63:0]          DDRAM_DOUT,
    input  logic                 DDRAM_DOUT_READY
);

    typedef enum logic [2:0] {
        IDLE,
        WCAP,
        WREQ,
        RREQ,
        RWAIT,
        ERR1,
        ERR2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic        acc;
    logic        legal;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [63:0] hrdata_q;
    logic        unused_ok;

    assign unused_ok = ^{ahb.HADDR[31:29], ahb.HADDR[2:0],
                         ahb.HTRANS[0], ahb.HBURST};

    // Address phases are only sampled while our data phase is ready.
    assign acc = ((state == IDLE) || (state == ERR2)) &&
                 ahb.HSEL && ahb.HTRANS[1] && ahb.HREADY;
    assign legal = (ahb.HSIZE == 3'b011);

    assign DDRAM_BURSTCNT = 8'd1;
    assign ahb.HREADYOUT  = hreadyout;
    assign ahb.HRESP      = hresp;
    assign ahb.HRDATA     = hrdata_q;

    always_ff @(posedge HCLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        hreadyout = 1'b1;
        hresp     = 2'b00;
        unique case (state)
            IDLE, ERR2: begin
                if (state == ERR2) begin
                    hresp = 2'b01;
                end
                if (acc) begin
                    if (!legal) begin
                        state_n = ERR1;
                    end else if (ahb.HWRITE) begin
                        state_n = WCAP;
                    end else begin
                        state_n = RREQ;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            WCAP: begin
                hreadyout = 1'b0;
                state_n   = WREQ;
            end
            WREQ: begin
                hreadyout = 1'b0;
                if (!DDRAM_BUSY) begin
                    state_n = IDLE;
                end
            end
            RREQ: begin
                hreadyout = 1'b0;
                if (!DDRAM_BUSY) begin
                    state_n = RWAIT;
                end
            end
            RWAIT: begin
                hreadyout = 1'b0;
                if (DDRAM_DOUT_READY) begin
                    state_n = IDLE;
                end
            end
            ERR1: begin
                hreadyout = 1'b0;
                hresp     = 2'b01;
                state_n   = ERR2;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge RESETN) begin
        if (!RESETN) begin
            DDRAM_ADDR <= '0;
            DDRAM_RD   <= 1'b0;
            DDRAM_WE   <= 1'b0;
            DDRAM_DIN  <= '0;
            DDRAM_BE   <= '0;
            hrdata_q   <= '0;
        end else begin
            if (acc && legal) begin
                DDRAM_ADDR <= {ahb.HADDR[28:3], 3'b000};
                if (!ahb.HWRITE) begin
                    DDRAM_RD <= 1'b1;
                end
            end
            if (state == WCAP) begin
                DDRAM_DIN <= ahb.HWDATA;
                DDRAM_BE  <= ahb.HWSTRB;
                DDRAM_WE  <= 1'b1;
            end
            if ((state == WREQ) && !DDRAM_BUSY) begin
                DDRAM_WE <= 1'b0;
            end
            if ((state == RREQ) && !DDRAM_BUSY) begin
                DDRAM_RD <= 1'b0;
            end
            if ((state == RWAIT) && DDRAM_DOUT_READY) begin
                hrdata_q <= DDRAM_DOUT;
            end
        end
    end

endmodule

// File: tb/tb_ahb_to_psxddr.sv
// Directed bench for the AHB to PSX DDRAM bridge.
module tb_ahb_to_psxddr;
    logic        HCLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        DDRAM_BUSY = 1'b0;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic        DDRAM_RD;
    logic        DDRAM_WE;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic [63:0] DDRAM_DOUT = '0;
    logic        DDRAM_DOUT_READY = 1'b0;

    int total = 0;
    int bad = 0;
    int we_cnt = 0;
    int rd_cnt = 0;
    int both_cnt = 0;

    ahb_to_psxddr_if bus ();

    assign bus.HREADY = bus.HREADYOUT;

    ahb_to_psxddr dut (
        .HCLK             (HCLK),
        .RESETN           (RESETN),
        .ahb              (bus),
        .DDRAM_BUSY       (DDRAM_BUSY),
        .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
        .DDRAM_ADDR       (DDRAM_ADDR),
        .DDRAM_RD         (DDRAM_RD),
        .DDRAM_WE         (DDRAM_WE),
        .DDRAM_DIN        (DDRAM_DIN),
        .DDRAM_BE         (DDRAM_BE),
        .DDRAM_DOUT       (DDRAM_DOUT),
        .DDRAM_DOUT_READY (DDRAM_DOUT_READY)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) begin
        if (DDRAM_WE && !DDRAM_BUSY) we_cnt++;
        if (DDRAM_RD && !DDRAM_BUSY) rd_cnt++;
        if (DDRAM_WE && DDRAM_RD) both_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic addr_ph(input logic [31:0] a, input logic w,
                           input logic [2:0] sz);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = a;
        bus.HWRITE = w;
        bus.HSIZE  = sz;
    endtask

    task automatic bus_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
    endtask

    task automatic cyc();
        @(negedge HCLK);
    endtask

    initial begin
        bus.HSEL   = 1'b0;
        bus.HADDR  = '0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = 3'b011;
        bus.HBURST = 3'b000;
        bus.HWSTRB = '0;
        bus.HWDATA = '0;

        cyc();
        cyc();
        chk("rst_rdy", 64'(bus.HREADYOUT), 64'd1);
        chk("rst_resp", 64'(bus.HRESP), 64'd0);
        chk("rst_hrdata", bus.HRDATA, 64'd0);
        chk("rst_rd", 64'(DDRAM_RD), 64'd0);
        chk("rst_we", 64'(DDRAM_WE), 64'd0);
        chk("rst_addr", 64'(DDRAM_ADDR), 64'd0);
        chk("rst_din", DDRAM_DIN, 64'd0);
        chk("rst_be", 64'(DDRAM_BE), 64'd0);
        chk("burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
        RESETN = 1'b1;
        cyc();

        // simple write, no stall
        addr_ph(32'h0000_0100, 1'b1, 3'b011);
        cyc();
        bus_idle();
        bus.HWDATA = 64'h1122334455667788;
        bus.HWSTRB = 8'h0F;
        chk("w1_rdy0", 64'(bus.HREADYOUT), 64'd0);
        chk("w1_we0", 64'(DDRAM_WE), 64'd0);
        cyc();
        chk("w1_rdy1", 64'(bus.HREADYOUT), 64'd0);
        chk("w1_we", 64'(DDRAM_WE), 64'd1);
        chk("w1_addr", 64'(DDRAM_ADDR), 64'h100);
        chk("w1_din", DDRAM_DIN, 64'h1122334455667788);
        chk("w1_be", 64'(DDRAM_BE), 64'h0F);
        cyc();
        chk("w1_done_rdy", 64'(bus.HREADYOUT), 64'd1);
        chk("w1_done_we", 64'(DDRAM_WE), 64'd0);
        chk("w1_we_cnt", 64'(we_cnt), 64'd1);

        // write stalled by DDRAM_BUSY for 5 cycles
        addr_ph(32'hE000_0208, 1'b1, 3'b011);
        cyc();
        bus_idle();
        bus.HWDATA = 64'hA5A5_5A5A_0F0F_F0F0;
        bus.HWSTRB = 8'hF0;
        DDRAM_BUSY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            bus.HWDATA = 64'h0;
            bus.HWSTRB = 8'h00;
            chk("w2_we", 64'(DDRAM_WE), 64'd1);
            chk("w2_addr", 64'(DDRAM_ADDR), 64'h208);
            chk("w2_din", DDRAM_DIN, 64'hA5A5_5A5A_0F0F_F0F0);
            chk("w2_be", 64'(DDRAM_BE), 64'hF0);
            chk("w2_rdy", 64'(bus.HREADYOUT), 64'd0);
        end
        DDRAM_BUSY = 1'b0;
        cyc();
        chk("w2_done_rdy", 64'(bus.HREADYOUT), 64'd1);
        chk("w2_done_we", 64'(DDRAM_WE), 64'd0);
        chk("w2_we_cnt", 64'(we_cnt), 64'd2);

        // read with data 4 cycles after acceptance
        addr_ph(32'h0000_02A8, 1'b0, 3'b011);
        cyc();
        bus_idle();
        chk("r1_rd", 64'(DDRAM_RD), 64'd1);
        chk("r1_addr", 64'(DDRAM_ADDR), 64'h2A8);
        chk("r1_rdy", 64'(bus.HREADYOUT), 64'd0);
        cyc();
        chk("r1_rd_drop", 64'(DDRAM_RD), 64'd0);
        chk("r1_rd_cnt", 64'(rd_cnt), 64'd1);
        cyc();
        chk("r1_wait_rdy", 64'(bus.HREADYOUT), 64'd0);
        chk("r1_wait_data", bus.HRDATA, 64'd0);
        cyc();
        DDRAM_DOUT = 64'hDEADBEEFCAFEF00D;
        DDRAM_DOUT_READY = 1'b1;
        cyc();
        DDRAM_DOUT_READY = 1'b0;
        DDRAM_DOUT = 64'h0;
        chk("r1_data", bus.HRDATA, 64'hDEADBEEFCAFEF00D);
        chk("r1_rdy_done", 64'(bus.HREADYOUT), 64'd1);
        chk("r1_resp", 64'(bus.HRESP), 64'd0);

        // illegal size gives two-cycle error
        addr_ph(32'h0000_0300, 1'b0, 3'b010);
        cyc();
        bus_idle();
        chk("e_rdy1", 64'(bus.HREADYOUT), 64'd0);
        chk("e_resp1", 64'(bus.HRESP), 64'd1);
        chk("e_rd", 64'(DDRAM_RD), 64'd0);
        cyc();
        chk("e_rdy2", 64'(bus.HREADYOUT), 64'd1);
        chk("e_resp2", 64'(bus.HRESP), 64'd1);
        cyc();
        chk("e_resp_end", 64'(bus.HRESP), 64'd0);
        chk("e_addr_kept", 64'(DDRAM_ADDR), 64'h2A8);
        chk("e_rd_cnt", 64'(rd_cnt), 64'd1);
        chk("e_we_cnt", 64'(we_cnt), 64'd2);

        // stray DOUT_READY outside RWAIT is ignored
        DDRAM_DOUT = 64'h1111_2222_3333_4444;
        DDRAM_DOUT_READY = 1'b1;
        cyc();
        DDRAM_DOUT_READY = 1'b0;
        chk("stray_data", bus.HRDATA, 64'hDEADBEEFCAFEF00D);
        chk("stray_rdy", 64'(bus.HREADYOUT), 64'd1);

        // back-to-back write then read
        addr_ph(32'h0000_0400, 1'b1, 3'b011);
        cyc();
        addr_ph(32'h0000_04A0, 1'b0, 3'b011);
        bus.HWDATA = 64'h0123456789ABCDEF;
        bus.HWSTRB = 8'hFF;
        cyc();
        chk("bb_we", 64'(DDRAM_WE), 64'd1);
        chk("bb_waddr", 64'(DDRAM_ADDR), 64'h400);
        chk("bb_rd_off", 64'(DDRAM_RD), 64'd0);
        cyc();
        chk("bb_wdone", 64'(bus.HREADYOUT), 64'd1);
        chk("bb_we_cnt", 64'(we_cnt), 64'd3);
        cyc();
        bus_idle();
        chk("bb_rd", 64'(DDRAM_RD), 64'd1);
        chk("bb_raddr", 64'(DDRAM_ADDR), 64'h4A0);
        chk("bb_rd_cnt0", 64'(rd_cnt), 64'd1);
        cyc();
        DDRAM_DOUT = 64'h55AA_55AA_0000_FFFF;
        DDRAM_DOUT_READY = 1'b1;
        cyc();
        DDRAM_DOUT_READY = 1'b0;
        chk("bb_data", bus.HRDATA, 64'h55AA_55AA_0000_FFFF);
        chk("bb_rd_cnt", 64'(rd_cnt), 64'd2);
        chk("bb_we_cnt2", 64'(we_cnt), 64'd3);

        // reset during RWAIT abandons the read
        addr_ph(32'h0000_0500, 1'b0, 3'b011);
        cyc();
        bus_idle();
        cyc();
        chk("rr_wait_rdy", 64'(bus.HREADYOUT), 64'd0);
        RESETN = 1'b0;
        #1;
        chk("rr_rdy", 64'(bus.HREADYOUT), 64'd1);
        chk("rr_rd", 64'(DDRAM_RD), 64'd0);
        chk("rr_data", bus.HRDATA, 64'd0);
        chk("rr_addr", 64'(DDRAM_ADDR), 64'd0);
        cyc();
        RESETN = 1'b1;
        cyc();
        DDRAM_DOUT = 64'hFFFF_FFFF_FFFF_FFFF;
        DDRAM_DOUT_READY = 1'b1;
        cyc();
        DDRAM_DOUT_READY = 1'b0;
        cyc();
        chk("rr_post_rdy", 64'(bus.HREADYOUT), 64'd1);
        chk("rr_post_data", bus.HRDATA, 64'd0);
        chk("no_overlap", 64'(both_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
